// File: rtl/mm_pkg.sv
// Shared definitions for the matrix multiplier / divider datapaths:
// FSM state encoding, default widths and a two's-complement sign helper.
package mm_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_QW         = 2 * DEF_DATA_WIDTH;
  localparam int DEF_CNT_W      = $clog2(DEF_QW);

  // Widest operand the sign helper handles; callers zero-extend in and cast back down.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  // Two's-complement negate when neg is set; with neg = sign bit this yields |value|.
  function automatic logic [MAX_W-1:0] cond_neg(input logic neg,
                                                input logic [MAX_W-1:0] value);
    return neg ? (~value + MAX_W'(1)) : value;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the partial remainder left, bring in the
// next dividend bit, and subtract the divisor magnitude when it fits.
module div_step
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH:0]   prem,
  input  logic                  bit_in,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   prem_next,
  output logic                  quot_bit
);

  logic [DATA_WIDTH+1:0] shifted;

  always_comb begin
    shifted   = {prem, bit_in};
    quot_bit  = (shifted >= (DATA_WIDTH+2)'(divisor));
    prem_next = quot_bit ? (DATA_WIDTH+1)'(shifted - (DATA_WIDTH+2)'(divisor))
                         : (DATA_WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: 2*DATA_WIDTH-bit dividend by DATA_WIDTH-bit divisor,
// one restoring step per clock, valid/ready handshake on input and output.
module seq_divider
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0]   in_divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_quot,
  output logic [DATA_WIDTH-1:0]   out_rem,
  output logic                    out_div_zero,
  output logic                    out_ovf
);

  localparam int DW    = DATA_WIDTH;
  localparam int QW    = 2 * DW;
  localparam int CNT_W = $clog2(QW);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // dvd_q starts as |dividend| and fills with quotient bits from the LSB as it shifts out.
  logic [QW-1:0] dvd_q;
  logic [DW-1:0] dvs_q;
  logic [DW:0]   prem_q;
  logic          neg_quot;
  logic          neg_rem;
  logic          div_zero;
  logic          ovf;

  logic          accept;
  logic          divisor_zero;
  logic          is_ovf;
  logic [QW-1:0] abs_dvd;
  logic [DW-1:0] abs_dvs;
  logic [QW-1:0] quot_fixed;
  logic [DW-1:0] rem_fixed;
  logic [DW:0]   prem_next;
  logic          quot_bit;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    divisor_zero = (in_divisor == '0);
    is_ovf       = (in_dividend == {1'b1, {(QW-1){1'b0}}}) && (in_divisor == '1);
    abs_dvd      = QW'(cond_neg(in_dividend[QW-1], MAX_W'(in_dividend)));
    abs_dvs      = DW'(cond_neg(in_divisor[DW-1], MAX_W'(in_divisor)));
    quot_fixed   = QW'(cond_neg(neg_quot, MAX_W'(dvd_q)));
    rem_fixed    = DW'(cond_neg(neg_rem, MAX_W'(prem_q[DW-1:0])));
  end

  div_step #(
    .DATA_WIDTH(DW)
  ) u_step (
    .prem      (prem_q),
    .bit_in    (dvd_q[QW-1]),
    .divisor   (dvs_q),
    .prem_next (prem_next),
    .quot_bit  (quot_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_quot     <= '0;
      out_rem      <= '0;
      out_div_zero <= 1'b0;
      out_ovf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            state <= divisor_zero ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(QW - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          out_valid    <= 1'b1;
          out_div_zero <= div_zero;
          out_ovf      <= ovf;
          if (div_zero) begin
            out_quot <= '0;
            out_rem  <= dvd_q[DW-1:0];
          end else begin
            out_quot <= quot_fixed;
            out_rem  <= rem_fixed;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: working registers carry no reset; they are always loaded at accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_quot <= in_dividend[QW-1] ^ in_divisor[DW-1];
      neg_rem  <= in_dividend[QW-1];
      div_zero <= divisor_zero;
      ovf      <= is_ovf;
      // A zero divisor keeps the raw dividend so its low bits can be reported as the remainder.
      dvd_q    <= divisor_zero ? in_dividend : abs_dvd;
      dvs_q    <= abs_dvs;
      prem_q   <= '0;
    end else if (state == ST_CALC) begin
      dvd_q  <= {dvd_q[QW-2:0], quot_bit};
      prem_q <= prem_next;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (DATA_WIDTH=4): vector table, random
// operands against a behavioural model, backpressure and mid-run reset.
module tb_seq_divider;

  localparam int DW      = 4;
  localparam int QW      = 2 * DW;
  localparam int LAT     = QW + 2;
  localparam int LAT_DZ  = 2;
  localparam int TIMEOUT = 40;

  typedef struct packed {
    logic [QW-1:0] quot;
    logic [DW-1:0] rem;
    logic          dz;
    logic          ovf;
  } exp_t;

  typedef struct {
    logic [QW-1:0] dvd;
    logic [DW-1:0] dvs;
    exp_t          exp;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] in_dividend;
  logic [DW-1:0] in_divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_quot;
  logic [DW-1:0] out_rem;
  logic          out_div_zero;
  logic          out_ovf;

  int   total;
  int   bad;
  exp_t exp_q[$];
  vec_t vecs[13];

  seq_divider #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quot     (out_quot),
    .out_rem      (out_rem),
    .out_div_zero (out_div_zero),
    .out_ovf      (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: SV integer / and % truncate toward zero, remainder takes dividend sign.
  function automatic exp_t model(input logic [QW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int   sa, sb, q, r;
    e = '0;
    if (b == '0) begin
      e.rem = a[DW-1:0];
      e.dz  = 1'b1;
    end else if (a == 8'h80 && b == 4'hF) begin
      e.quot = 8'h80;
      e.ovf  = 1'b1;
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      e.quot = q[QW-1:0];
      e.rem  = r[DW-1:0];
    end
    return e;
  endfunction

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic send(input logic [QW-1:0] dvd, input logic [DW-1:0] dvs, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check("in_ready before send", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_dividend = dvd;
    in_divisor  = dvs;
    @(posedge clk);
    exp_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  // Waits for out_valid counting cycles since accept, compares against the scoreboard, retires it.
  task automatic collect(input int exp_lat, input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < TIMEOUT);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    if (!out_valid) return;
    check({tag, " scoreboard"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({tag, " quot"}, 32'(out_quot), 32'(e.quot));
    check({tag, " rem"}, 32'(out_rem), 32'(e.rem));
    check({tag, " div_zero"}, 32'(out_div_zero), 32'(e.dz));
    check({tag, " ovf"}, 32'(out_ovf), 32'(e.ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    logic [QW-1:0] rd;
    logic [DW-1:0] rs;

    total = 0;
    bad   = 0;
    //           dividend divisor   quot   rem   dz    ovf
    vecs[0]  = '{8'h2D, 4'h6, {8'h07, 4'h3, 1'b0, 1'b0}};
    vecs[1]  = '{8'hD3, 4'h6, {8'hF9, 4'hD, 1'b0, 1'b0}};
    vecs[2]  = '{8'h7F, 4'h8, {8'hF1, 4'h7, 1'b0, 1'b0}};
    vecs[3]  = '{8'h80, 4'hF, {8'h80, 4'h0, 1'b0, 1'b1}};
    vecs[4]  = '{8'h11, 4'h0, {8'h00, 4'h1, 1'b1, 1'b0}};
    vecs[5]  = '{8'h64, 4'h7, {8'h0E, 4'h2, 1'b0, 1'b0}};
    vecs[6]  = '{8'h80, 4'h7, {8'hEE, 4'hE, 1'b0, 1'b0}};
    vecs[7]  = '{8'h80, 4'h1, {8'h80, 4'h0, 1'b0, 1'b0}};
    vecs[8]  = '{8'h07, 4'h8, {8'h00, 4'h7, 1'b0, 1'b0}};
    vecs[9]  = '{8'hFF, 4'h8, {8'h00, 4'hF, 1'b0, 1'b0}};
    vecs[10] = '{8'h80, 4'h0, {8'h00, 4'h0, 1'b1, 1'b0}};
    vecs[11] = '{8'h7F, 4'h1, {8'h7F, 4'h0, 1'b0, 1'b0}};
    vecs[12] = '{8'h81, 4'hF, {8'h7F, 4'h0, 1'b0, 1'b0}};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_quot", 32'(out_quot), 32'd0);
    check("reset out_rem", 32'(out_rem), 32'd0);
    check("reset out_div_zero", 32'(out_div_zero), 32'd0);
    check("reset out_ovf", 32'(out_ovf), 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i].dvd, vecs[i].dvs, vecs[i].exp);
      collect(vecs[i].exp.dz ? LAT_DZ : LAT, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      rd = QW'($urandom);
      rs = DW'($urandom);
      send(rd, rs, model(rd, rs));
      collect((rs == '0) ? LAT_DZ : LAT, $sformatf("rnd%0d %0h/%0h", i, rd, rs));
    end

    // Backpressure: result held for 5 cycles, new operands offered but ignored.
    send(8'h2D, 4'h6, vecs[0].exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < TIMEOUT);
    check("bp latency", 32'(n), 32'(LAT));
    in_valid    = 1'b1;
    in_dividend = 8'h64;
    in_divisor  = 4'h7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp hold%0d quot", i), 32'(out_quot), 32'h07);
      check($sformatf("bp hold%0d rem", i), 32'(out_rem), 32'h3);
    end
    e = exp_q.pop_front();
    check("bp scoreboard quot", 32'(out_quot), 32'(e.quot));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp retire out_valid", 32'(out_valid), 32'd0);
    check("bp no accept on retire", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(vecs[5].exp);
    #1 in_valid = 1'b0;
    collect(LAT, "bp next 100/7");

    // Reset during CALC iteration 3 discards the division in flight.
    send(8'h2D, 4'h6, vecs[0].exp);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset out_quot", 32'(out_quot), 32'd0);
    check("midreset out_rem", 32'(out_rem), 32'd0);
    send(8'h64, 4'h7, vecs[5].exp);
    collect(LAT, "after reset 100/7");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
